// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: program sequencer that drives the register/ALU datapath.
// It fetches 16-bit instruction words in order from a loadable program store.
// It decodes each word into ALU_Operation/Rd/Rs/Rt and issues a one-cycle
// execute strobe per instruction. The run stops at a HALT word or at the end
// of the store.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step_mode/step ports
// and a PAUSE state, which pauses after every issue for board-level debug.
module alu_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic [2:0]    ALU_Operation,
  output logic [3:0]    Rd,
  output logic [3:0]    Rs,
  output logic [3:0]    Rt,
  output logic          execute,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_PAUSE = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          halt_q, halt_d;     // HALT flag of the word in the instruction register
  logic [2:0]    op_q, op_d;
  logic [3:0]    rd_q, rd_d;
  logic [3:0]    rs_q, rs_d;
  logic [3:0]    rt_q, rt_d;
  logic          exec_q, exec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_prev_q, step_prev_d;
  logic          step_rise;
`endif

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   fetch_word;
  logic          wr_en;
  logic          at_end;

  // The store is writable only while no run is in progress.
  assign wr_en      = load_en && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign fetch_word = mem_q[pc_q];
  assign at_end     = (pc_q == AW'(DEPTH - 1));
`ifdef SEQ_SINGLE_STEP_EN
  assign step_rise  = step && !step_prev_q;
`endif

  // Program store: synchronous write; the FETCH state reads the word into the
  // instruction register.
  // NOTE: the program store has no reset branch. Resetting it would need a
  // clear path to every word, and the program must survive a run abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[load_addr] <= load_data;
  end

  // Next-state and next-output logic of the sequencer FSM.
  // NOTE: each _d signal gets a default before the case statement. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    exec_d  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_prev_d = step;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        // Fields and strobe are registered here so they appear together in ISSUE.
        halt_d  = fetch_word[12];
        state_d = S_ISSUE;
        if (!fetch_word[12]) begin
          op_d   = fetch_word[15:13];
          rd_d   = fetch_word[11:8];
          rs_d   = fetch_word[7:4];
          rt_d   = fetch_word[3:0];
          exec_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (halt_q || at_end) begin
          state_d = S_DONE;
`ifdef SEQ_SINGLE_STEP_EN
        end else if (step_mode) begin
          state_d = S_PAUSE;
`endif
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + AW'(1);
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step_rise) begin
          state_d = S_FETCH;
          pc_d    = pc_q + AW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-high reset.
  // NOTE: use non-blocking assignments. Every flop then samples its _d value
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      halt_q  <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      exec_q  <= exec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_SINGLE_STEP_EN
      step_prev_q <= step_prev_d;
`endif
    end
  end

  assign ALU_Operation = op_q;
  assign Rd            = rd_q;
  assign Rs            = rs_q;
  assign Rt            = rt_q;
  assign execute       = exec_q;
  assign pc            = pc_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Testbench for alu_instr_sequencer. The stimulus process loads programs and
// starts runs, and pushes each expected issue into a queue. A monitor pops and
// compares the queue on every execute pulse. The single-step section is built
// only when SEQ_SINGLE_STEP_EN is defined.
module tb_alu_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          start;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_mode;
  logic          step;
`endif
  logic [2:0]    ALU_Operation;
  logic [3:0]    Rd, Rs, Rt;
  logic          execute;
  logic [AW-1:0] pc;
  logic          busy, done;

  alu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .ALU_Operation(ALU_Operation), .Rd(Rd), .Rs(Rs), .Rt(Rt),
    .execute(execute), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } fields_t;

  fields_t     exp_q[$];
  logic [15:0] prog [DEPTH];   // reference copy of the program store
  fields_t     last_f;         // fields of the last instruction that should have issued
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic fields_t decode(input logic [15:0] w);
    fields_t f;
    f.op = w[15:13];
    f.rd = w[11:8];
    f.rs = w[7:4];
    f.rt = w[3:0];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every execute pulse must match the oldest expected issue.
  initial begin
    fields_t e;
    forever begin
      @(negedge clk);
      if (execute === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_execute", 32'(execute), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("issue_fields", 32'({ALU_Operation, Rd, Rs, Rt}), 32'(e));
          check("busy_done_on_issue", 32'({busy, done}), 32'b10);
        end
      end
    end
  end

  // Watchdog against a hang anywhere in the stimulus.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic load_word(input int a, input logic [15:0] w);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = w;
    @(posedge clk); #1;
    load_en   = 1'b0;
    prog[a]   = w;
  endtask

  // Random program; halt_odds = 0 means no HALT words, otherwise 1 in halt_odds.
  task automatic load_random(input int halt_odds);
    logic [15:0] w;
    for (int a = 0; a < DEPTH; a++) begin
      w     = 16'($urandom);
      w[12] = (halt_odds > 0) && ($urandom_range(0, halt_odds - 1) == 0);
      load_word(a, w);
    end
  endtask

  // Walk the reference program: one issue per word until HALT or end of store.
  task automatic build_expect(output int n_exp, output int fetched, output int last_a);
    n_exp = 0; fetched = 0; last_a = 0;
    for (int a = 0; a < DEPTH; a++) begin
      fetched = a + 1;
      last_a  = a;
      if (prog[a][12]) break;
      exp_q.push_back(decode(prog[a]));
      last_f = decode(prog[a]);
      n_exp++;
    end
  endtask

  // Free-run one program. Optionally write address 0 together with start, and
  // optionally attempt a write to address 1 at cycle gate_cyc of the run.
  task automatic run_prog(input int gate_cyc, input logic [15:0] gate_data,
                          input bit load0, input logic [15:0] load0_data);
    int n_exp, fetched, last_a, pulses, done_cyc;
    bit gap_ok;
    if (load0) prog[0] = load0_data;
    build_expect(n_exp, fetched, last_a);
    load_en   = load0;
    load_addr = '0;
    load_data = load0_data;
    start     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    load_en = 1'b0;
    pulses = 0; done_cyc = -1; gap_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (c == gate_cyc) begin
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = gate_data;
      end
      @(negedge clk);
      if (execute === 1'b1) begin
        pulses++;
        if (c != 2 * pulses) gap_ok = 1'b0;
      end
      if (c == gate_cyc) check("busy_at_gated_load", 32'(busy), 32'd1);
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
      load_en = 1'b0;
    end
    load_en = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(2 * fetched + 1));
    check("pulse_count", 32'(pulses), 32'(n_exp));
    check("pulse_spacing", 32'(gap_ok), 32'd1);
    check("pc_at_done", 32'(pc), 32'(last_a));
    check("busy_at_done", 32'(busy), 32'd0);
    check("held_fields", 32'({ALU_Operation, Rd, Rs, Rt}), 32'(last_f));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic count_pulses(input int ncyc, inout int n);
    repeat (ncyc) begin
      @(negedge clk);
      if (execute === 1'b1) n++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    last_f = '0;
    exp_q.delete();
  endtask

  initial begin
    int n_exp, fetched, last_a;
    logic [15:0] w;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    last_f = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({pc, ALU_Operation, Rd, Rs, Rt, execute, busy, done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: add, sub, HALT.
    load_word(0, 16'h0321);
    load_word(1, 16'h2456);
    load_word(2, 16'h1000);
    run_prog(0, 16'h0, 1'b0, 16'h0);

    // End of store: 16 non-HALT words, pc must stop at DEPTH-1.
    load_random(0);
    run_prog(0, 16'h0, 1'b0, 16'h0);

    // Load gating: a write while busy is dropped; the rerun issues the original word.
    w = ~prog[1];
    run_prog(3, w, 1'b0, 16'h0);
    run_prog(0, 16'h0, 1'b0, 16'h0);

    // Simultaneous load and start: the first issue uses the freshly written word.
    w = prog[0] ^ 16'hE0FF;
    w[12] = 1'b0;
    run_prog(0, 16'h0, 1'b1, w);

    // Mid-run reset: abort and no execute in the cycle after the reset edge.
    load_random(0);
    build_expect(n_exp, fetched, last_a);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrun_reset_state",
          32'({pc, ALU_Operation, Rd, Rs, Rt, execute, busy, done}), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    last_f = '0;
    exp_q.delete();

    // Randomized programs with occasional HALT words.
    repeat (6) begin
      load_random(6);
      run_prog(0, 16'h0, 1'b0, 16'h0);
    end

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: one pulse, then nothing until a step edge; a held level advances once.
    begin
      int n;
      for (int a = 0; a < 3; a++) begin
        w = 16'($urandom);
        w[12] = 1'b0;
        load_word(a, w);
      end
      load_word(3, 16'h1000);
      build_expect(n_exp, fetched, last_a);
      step_mode = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      count_pulses(12, n);
      check("step_first_pulse_only", 32'(n), 32'd1);
      check("step_busy_in_pause", 32'({busy, done}), 32'b10);
      n = 0;
      step = 1'b1;
      count_pulses(5, n);
      step = 1'b0;
      count_pulses(3, n);
      check("step_held_one_pulse", 32'(n), 32'd1);
      apply_reset();
      step_mode = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
